bus_write_sequencer: RTL and testbench

- Sequences one write of a byte onto the shared 8-bit data bus through the downstream octal tri-state buffer.
- Feeds the buffer's D1..D8 data inputs and its EN and OE_n controls, both active low (drive only when EN=0 and OE_n=0).
- Upstream logic hands over one byte with a valid/ready handshake. The block waits for bus grant, applies setup, drive and turnaround timing, then reports completion or abort.
- Guarantees the buffer never drives while grant is low, and never drives during the turnaround gap.

---
 rtl/bus_write_sequencer_if.sv | 26 ++
 rtl/bus_write_sequencer.sv | 111 +++++++++++
 tb/tb_bus_write_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_write_sequencer_if.sv
// Handshake and buffer-control signals between upstream logic, the bus arbiter,
// the octal tri-state buffer and the write sequencer.
interface bus_write_sequencer_if;
    logic       req_valid;
    logic [7:0] req_data;
    logic       req_ready;
    logic       bus_grant;
    logic [7:0] buf_d;
    logic       buf_en_n;
    logic       buf_oe_n;
    logic       busy;
    logic       done;
    logic       abort;

    // master: the sequencer itself, which owns the buffer controls
    modport master (
        input  req_valid, req_data, bus_grant,
        output req_ready, buf_d, buf_en_n, buf_oe_n, busy, done, abort
    );

    // slave: the surrounding system (upstream producer, arbiter, buffer)
    modport slave (
        output req_valid, req_data, bus_grant,
        input  req_ready, buf_d, buf_en_n, buf_oe_n, busy, done, abort
    );
endinterface

// File: rtl/bus_write_sequencer.sv
// Writes one byte onto the shared bus through an octal tri-state buffer:
// accept, grant-qualified setup, drive, turnaround, then a done/abort pulse.
module bus_write_sequencer #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned TURN_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_write_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        DRIVE   = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);
    localparam logic [3:0] TURN_LD  = 4'(TURN_CYC - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [7:0] data_q;
    logic       en_n_q;
    logic       done_q;
    logic       abort_q;
    logic       abort_flag_q;

    // NOTE: the buffer enable is its own flop, set on the same edge as the state
    // transition, so bus_grant never reaches buf_en_n/buf_oe_n combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            data_q       <= 8'h00;
            en_n_q       <= 1'b1;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
            abort_flag_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        data_q  <= bus.req_data;
                        cnt_q   <= SETUP_LD;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (bus.bus_grant) begin
                        if (cnt_q == 4'd0) begin
                            cnt_q   <= HOLD_LD;
                            en_n_q  <= 1'b0;
                            state_q <= DRIVE;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                DRIVE: begin
                    // Grant loss wins over normal expiry so the abort is never missed.
                    if (!bus.bus_grant) begin
                        abort_flag_q <= 1'b1;
                        cnt_q        <= TURN_LD;
                        en_n_q       <= 1'b1;
                        state_q      <= RELEASE;
                    end else if (cnt_q == 4'd0) begin
                        cnt_q   <= TURN_LD;
                        en_n_q  <= 1'b1;
                        state_q <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == 4'd0) begin
                        done_q  <= 1'b1;
                        abort_q <= abort_flag_q;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    abort_flag_q <= 1'b0;
                    cnt_q        <= 4'd0;
                    state_q      <= IDLE;
                end
                default: begin
                    en_n_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.buf_d     = data_q;
    assign bus.buf_en_n  = en_n_q;
    assign bus.buf_oe_n  = en_n_q;
    assign bus.done      = done_q;
    assign bus.abort     = abort_q;

endmodule

// File: tb/tb_bus_write_sequencer.sv
// Self-checking bench: two sequencer instances (default and S=3/H=4/T=2) share
// stimulus and are compared every cycle against a transaction-phase model.
module tb_bus_write_sequencer;

    localparam int SA = 1, HA = 2, TA = 1;
    localparam int SB = 3, HB = 4, TB = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_write_sequencer_if ifa ();
    bus_write_sequencer_if ifb ();

    bus_write_sequencer #(.SETUP_CYC(SA), .HOLD_CYC(HA), .TURN_CYC(TA)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    bus_write_sequencer #(.SETUP_CYC(SB), .HOLD_CYC(HB), .TURN_CYC(TB)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: where the current transfer is, and how many qualifying cycles of
    // that phase have elapsed so far (counting up from zero).
    typedef enum int {P_IDLE, P_SETUP, P_DRIVE, P_TURN, P_DONE} phase_t;
    typedef struct {
        phase_t     ph;
        int         n;
        bit         ab;
        logic [7:0] data;
    } mdl_t;

    mdl_t ma, mb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic mdl_t mdl_idle();
        mdl_t r;
        r.ph = P_IDLE; r.n = 0; r.ab = 1'b0; r.data = 8'h00;
        return r;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int s, input int h, input int t,
                                      input bit v, input logic [7:0] d, input bit g);
        mdl_t r = m;
        case (m.ph)
            P_IDLE:  if (v) begin r.data = d; r.n = 0; r.ph = P_SETUP; end
            P_SETUP: if (g) begin
                r.n = m.n + 1;
                if (r.n == s) begin r.ph = P_DRIVE; r.n = 0; end
            end
            P_DRIVE: if (!g) begin
                r.ab = 1'b1; r.ph = P_TURN; r.n = 0;
            end else begin
                r.n = m.n + 1;
                if (r.n == h) begin r.ph = P_TURN; r.n = 0; end
            end
            P_TURN: begin
                r.n = m.n + 1;
                if (r.n == t) begin r.ph = P_DONE; r.n = 0; end
            end
            P_DONE: begin r.ph = P_IDLE; r.ab = 1'b0; end
            default: r = mdl_idle();
        endcase
        return r;
    endfunction

    task automatic check_outs(input string p, input mdl_t m, input logic rdy, input logic bsy,
                              input logic en_n, input logic oe_n, input logic dn, input logic ab,
                              input logic [7:0] d, input logic g);
        check({p, "_ready"}, 32'(rdy),  32'(m.ph == P_IDLE));
        check({p, "_busy"},  32'(bsy),  32'(m.ph != P_IDLE));
        check({p, "_en_n"},  32'(en_n), 32'(m.ph != P_DRIVE));
        check({p, "_oe_n"},  32'(oe_n), 32'(m.ph != P_DRIVE));
        check({p, "_done"},  32'(dn),   32'(m.ph == P_DONE));
        check({p, "_abort"}, 32'(ab),   32'((m.ph == P_DONE) && m.ab));
        check({p, "_buf_d"}, 32'(d),    32'(m.data));
        check({p, "_grant_inv"}, 32'((en_n === 1'b0) && !g), 32'(0));
    endtask

    task automatic check_both(input logic g);
        check_outs("a", ma, ifa.req_ready, ifa.busy, ifa.buf_en_n, ifa.buf_oe_n,
                   ifa.done, ifa.abort, ifa.buf_d, g);
        check_outs("b", mb, ifb.req_ready, ifb.busy, ifb.buf_en_n, ifb.buf_oe_n,
                   ifb.done, ifb.abort, ifb.buf_d, g);
    endtask

    task automatic drive_in(input bit v, input logic [7:0] d, input bit g);
        ifa.req_valid = v; ifa.req_data = d; ifa.bus_grant = g;
        ifb.req_valid = v; ifb.req_data = d; ifb.bus_grant = g;
    endtask

    // Inputs change away from the edge, model advances on the edge, outputs
    // are compared on the following falling edge.
    task automatic tick(input bit v, input logic [7:0] d, input bit g);
        drive_in(v, d, g);
        @(posedge clk);
        ma = mdl_step(ma, SA, HA, TA, v, d, g);
        mb = mdl_step(mb, SB, HB, TB, v, d, g);
        @(negedge clk);
        cyc++;
        check_both(g);
    endtask

    task automatic do_reset();
        drive_in(1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ma = mdl_idle();
        mb = mdl_idle();
        check_both(1'b1);
        cyc = 0;
    endtask

    // Asynchronous reset pulse between edges; bus must release immediately.
    task automatic mid_cycle_reset(input string tag);
        #1 reset = 1'b1;
        #1;
        check({tag, "_en_n"},  32'(ifa.buf_en_n),  32'(1));
        check({tag, "_oe_n"},  32'(ifa.buf_oe_n),  32'(1));
        check({tag, "_ready"}, 32'(ifa.req_ready), 32'(1));
        check({tag, "_b_en_n"}, 32'(ifb.buf_en_n), 32'(1));
        #1 reset = 1'b0;
        ma = mdl_idle();
        mb = mdl_idle();
    endtask

    initial begin
        int acc_a[$];
        int acc_b[$];
        logic [7:0] dat[32];
        bit seen_b;

        reset = 1'b1;
        drive_in(1'b0, 8'h00, 1'b0);

        // Default timing, grant held high.
        do_reset();
        for (int j = 0; j < 7; j++) begin
            tick(j == 0, (j == 0) ? 8'hA5 : 8'h00, 1'b1);
            check("t1_en_n",  32'(ifa.buf_en_n),  32'(!(cyc inside {2, 3})));
            check("t1_done",  32'(ifa.done),      32'(cyc == 5));
            check("t1_ready", 32'(ifa.req_ready), 32'(cyc >= 6));
            check("t1_buf_d", 32'(ifa.buf_d),     32'h A5);
            if (cyc == 5) check("t1_abort", 32'(ifa.abort), 32'(0));
        end

        // Grant low at accept, raised in cycle 4.
        do_reset();
        for (int j = 0; j < 10; j++) begin
            tick(j == 0, 8'h5A, j >= 4);
            check("t2_en_n", 32'(ifa.buf_en_n), 32'(!(cyc inside {5, 6})));
            check("t2_done", 32'(ifa.done),     32'(cyc == 8));
            if (cyc == 8) check("t2_abort", 32'(ifa.abort), 32'(0));
        end

        // Grant dropped in the first drive cycle.
        do_reset();
        for (int j = 0; j < 8; j++) begin
            tick(j == 0, 8'hC3, j != 2);
            check("t3_en_n", 32'(ifa.buf_en_n), 32'(cyc != 2));
            check("t3_done", 32'(ifa.done),     32'(cyc == 4));
            if (cyc == 4) check("t3_abort", 32'(ifa.abort), 32'(1));
        end

        // Reset pulsed while driving, then a clean transfer.
        do_reset();
        tick(1'b1, 8'h99, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        check("t4_driving", 32'(ifa.buf_en_n), 32'(0));
        mid_cycle_reset("t4_rst");
        for (int j = 0; j < 5; j++) begin
            tick(1'b0, 8'h00, 1'b1);
            check("t4_no_done", 32'(ifa.done),      32'(0));
            check("t4_idle",    32'(ifa.req_ready), 32'(1));
        end
        cyc = 0;
        for (int j = 0; j < 7; j++) begin
            tick(j == 0, 8'h3C, 1'b1);
            check("t4_done", 32'(ifa.done), 32'(cyc == 5));
            if (cyc == 5) check("t4_abort", 32'(ifa.abort), 32'(0));
            check("t4_buf_d", 32'(ifa.buf_d), 32'h3C);
        end

        // req_valid held high with changing data: no queuing, fixed spacing.
        do_reset();
        seen_b = 1'b0;
        for (int j = 0; j < 30; j++) begin
            dat[j] = 8'($urandom);
            if (ifa.req_ready) acc_a.push_back(j);
            if (ifb.req_ready) acc_b.push_back(j);
            tick(1'b1, dat[j], 1'b1);
            if (!seen_b && ifb.buf_en_n === 1'b0 && acc_b.size() > 0) begin
                seen_b = 1'b1;
                check("t5_first_byte_b", 32'(ifb.buf_d), 32'(dat[acc_b[0]]));
            end
        end
        check("t5_nacc_a", 32'(acc_a.size() >= 2), 32'(1));
        check("t5_nacc_b", 32'(acc_b.size() >= 2), 32'(1));
        if (acc_a.size() >= 2) check("t5_gap_a", 32'(acc_a[1] - acc_a[0]), 32'(SA + HA + TA + 2));
        if (acc_b.size() >= 2) check("t5_gap_b", 32'(acc_b[1] - acc_b[0]), 32'(11));
        check("t5_drive_seen_b", 32'(seen_b), 32'(1));

        // Randomized traffic with occasional asynchronous resets.
        for (int k = 0; k < 5; k++) begin
            do_reset();
            for (int j = 0; j < 350; j++) begin
                tick($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 9) < 8);
                if ($urandom_range(0, 99) == 0) mid_cycle_reset("rnd_rst");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
